fifo_sync_param: RTL

Parametrised single-clock FIFO, the next generation of the team's 128-bit `fifo1` buffer used between the feature-extraction and ELM stages. It generalises data width and depth, and adds a selectable first-word-fall-through read mode, almost-full/almost-empty thresholds, a live fill level, synchronous flush and sticky overflow/underflow flags. Both sides share one clock.

---
 rtl/fifo_pkg.sv | 28 ++
 rtl/fifo_sync_param_if.sv | 33 +++
 rtl/fifo_mem.sv | 37 +++
 rtl/fifo_sync_param.sv | 101 ++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults and pointer-compare helper for the parametrised sync FIFO.
package fifo_pkg;

  localparam int unsigned DEF_DSIZE     = 128;
  localparam int unsigned DEF_ASIZE     = 4;
  localparam int unsigned DEF_AFULL_TH  = (2 ** DEF_ASIZE) - 2;
  localparam int unsigned DEF_AEMPTY_TH = 2;

  typedef struct packed {
    logic full;
    logic empty;
  } ptr_flags_t;

  // Pointers carry one wrap bit above the asize address bits.
  function automatic ptr_flags_t ptr_compare(input logic [31:0] wptr,
                                             input logic [31:0] rptr,
                                             input int unsigned asize);
    logic [31:0] mask;
    logic [31:0] diff;
    ptr_flags_t  f;
    mask    = (32'(1) << (asize + 1)) - 32'(1);
    diff    = (wptr ^ rptr) & mask;
    f.empty = (diff == 32'(0));
    f.full  = (diff == (32'(1) << asize));
    return f;
  endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// Write/read/status bundle between a FIFO user (master) and the FIFO (slave).
interface fifo_sync_param_if import fifo_pkg::*; #(
  parameter int unsigned DSIZE = DEF_DSIZE,
  parameter int unsigned ASIZE = DEF_ASIZE
) ();

  logic             flush;
  logic             winc;
  logic [DSIZE-1:0] wdata;
  logic             wfull;
  logic             walmost_full;
  logic             rinc;
  logic [DSIZE-1:0] rdata;
  logic             rvalid;
  logic             rempty;
  logic             ralmost_empty;
  logic [ASIZE:0]   level;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, winc, wdata, rinc,
    input  wfull, walmost_full, rdata, rvalid, rempty, ralmost_empty,
           level, overflow, underflow
  );

  modport slave (
    input  flush, winc, wdata, rinc,
    output wfull, walmost_full, rdata, rvalid, rempty, ralmost_empty,
           level, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DSIZE storage: synchronous write, registered or fall-through read.
module fifo_mem #(
  parameter int unsigned DSIZE = 128,
  parameter int unsigned ASIZE = 4,
  parameter bit          FWFT  = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic             re,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ASIZE;

  logic [DSIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  generate
    if (FWFT) begin : g_fwft
      // re means "head word valid"; output is zero otherwise.
      assign rdata = (re && !clr) ? mem[raddr] : '0;
    end else begin : g_reg
      always_ff @(posedge clk) begin
        if (clr)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
      end
    end
  endgenerate

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO with flush, thresholds, fill level and sticky error flags.
module fifo_sync_param import fifo_pkg::*; #(
  parameter int unsigned DSIZE     = DEF_DSIZE,
  parameter int unsigned ASIZE     = DEF_ASIZE,
  parameter int unsigned AFULL_TH  = (2 ** ASIZE) - 2,
  parameter int unsigned AEMPTY_TH = DEF_AEMPTY_TH,
  parameter bit          FWFT      = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  fifo_sync_param_if.slave bus
);

  localparam int unsigned PW = ASIZE + 1;

  logic [PW-1:0] wptr_q, wptr_n, rptr_q, rptr_n, level_q, level_n;
  logic          wfull_q, wfull_n, rempty_q, rempty_n;
  logic          afull_q, afull_n, aempty_q, aempty_n;
  logic          ovf_q, ovf_n, unf_q, unf_n, rvalid_q, rvalid_n;
  logic          wr_acc, rd_acc, mem_re;
  ptr_flags_t    flags_n;

  // Next-state: acceptance uses pre-edge flags; flush overrides everything.
  always_comb begin
    wr_acc   = bus.winc && !wfull_q && !bus.flush;
    rd_acc   = bus.rinc && !rempty_q && !bus.flush;
    wptr_n   = wptr_q + PW'(wr_acc);
    rptr_n   = rptr_q + PW'(rd_acc);
    level_n  = level_q;
    if (wr_acc && !rd_acc)      level_n = level_q + PW'(1);
    else if (rd_acc && !wr_acc) level_n = level_q - PW'(1);
    ovf_n    = ovf_q | (bus.winc & wfull_q);
    unf_n    = unf_q | (bus.rinc & rempty_q);
    if (bus.flush) begin
      wptr_n  = '0;
      rptr_n  = '0;
      level_n = '0;
      ovf_n   = 1'b0;
      unf_n   = 1'b0;
    end
    flags_n  = ptr_compare(32'(wptr_n), 32'(rptr_n), ASIZE);
    wfull_n  = flags_n.full;
    rempty_n = flags_n.empty;
    afull_n  = (level_n >= PW'(AFULL_TH));
    aempty_n = (level_n <= PW'(AEMPTY_TH));
    rvalid_n = FWFT ? !rempty_n : rd_acc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      wfull_q  <= 1'b0;
      rempty_q <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_n;
      rptr_q   <= rptr_n;
      level_q  <= level_n;
      wfull_q  <= wfull_n;
      rempty_q <= rempty_n;
      afull_q  <= afull_n;
      aempty_q <= aempty_n;
      ovf_q    <= ovf_n;
      unf_q    <= unf_n;
      rvalid_q <= rvalid_n;
    end
  end

  assign mem_re = FWFT ? !rempty_q : rd_acc;

  fifo_mem #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE),
    .FWFT  (FWFT)
  ) u_mem (
    .clk   (clk),
    .clr   (!rst_n),
    .we    (wr_acc && rst_n),
    .waddr (wptr_q[ASIZE-1:0]),
    .wdata (bus.wdata),
    .re    (mem_re),
    .raddr (rptr_q[ASIZE-1:0]),
    .rdata (bus.rdata)
  );

  assign bus.wfull         = wfull_q;
  assign bus.walmost_full  = afull_q;
  assign bus.rvalid        = rvalid_q;
  assign bus.rempty        = rempty_q;
  assign bus.ralmost_empty = aempty_q;
  assign bus.level         = level_q;
  assign bus.overflow      = ovf_q;
  assign bus.underflow     = unf_q;

endmodule
